apu_frame_sequencer: RTL and testbench



---
 rtl/apu_frame_sequencer.sv | 166 ++++++++++++++++
 tb/tb_apu_frame_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apu_frame_sequencer.sv
// apu_frame_sequencer
//
// APU frame sequencer. A divider counts cpu_ce ticks; every STEP_CYCLES ticks
// a step boundary advances the step index, which selects the quarter-frame and
// half-frame clock-enable pulses for the envelopes, linear counter, length
// counters and sweeps. Programmed through a $4017-style write (mode, IRQ
// inhibit). Optionally raises the frame interrupt, cleared by a $4015 read.
//
// Configuration macro: APU_FRAME_IRQ_EN
//   defined   -> frame IRQ flag, inhibit bit and status_rd clearing present
//   undefined -> frame_irq tied low; wr_data[6] and status_rd ignored
//
// Parameters:
//   STEP_CYCLES    cpu_ce ticks per sequencer step (2..65535)
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   cpu_ce         one-clk CPU-cycle enable; gates all counting
//   wr_4017        frame control register write strobe
//   wr_data[7:0]   bit7 = mode (1 = 5-step), bit6 = IRQ inhibit
//   status_rd      $4015 read strobe; clears frame IRQ
//   quarter_frame  one-clk pulse: envelopes, triangle linear counter
//   half_frame     one-clk pulse: length counters, sweeps
//   frame_irq      frame interrupt flag (level)
//   step[2:0]      current step index
//   mode           registered sequence mode bit
module apu_frame_sequencer #(
  parameter int unsigned STEP_CYCLES = 7457
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_ce,
  input  logic       wr_4017,
  input  logic [7:0] wr_data,
  input  logic       status_rd,
  output logic       quarter_frame,
  output logic       half_frame,
  output logic       frame_irq,
  output logic [2:0] step,
  output logic       mode
);

  localparam logic [15:0] StepLast = 16'(STEP_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  step_q, step_d;
  logic        mode_q, mode_d;
  logic        quarter_q, quarter_d;
  logic        half_q, half_d;
  logic        boundary;
  logic [2:0]  step_reached;
  logic        irq_set;

  always_comb begin
    boundary     = cpu_ce && (cnt_q == StepLast);
    step_reached = step_q + 3'd1;
    cnt_d        = cnt_q;
    step_d       = step_q;
    mode_d       = mode_q;
    quarter_d    = 1'b0;
    half_d       = 1'b0;
    irq_set      = 1'b0;

    if (wr_4017) begin
      // A write restarts the sequence and cancels any coincident boundary.
      mode_d    = wr_data[7];
      cnt_d     = '0;
      step_d    = '0;
      quarter_d = wr_data[7];
      half_d    = wr_data[7];
    end else if (cpu_ce) begin
      if (boundary) begin
        cnt_d  = '0;
        step_d = step_reached;
        case (step_reached)
          3'd1, 3'd3: quarter_d = 1'b1;
          3'd2: begin
            quarter_d = 1'b1;
            half_d    = 1'b1;
          end
          3'd4: begin
            // 5-step mode: silent step, index stays visible as 4.
            if (!mode_q) begin
              quarter_d = 1'b1;
              half_d    = 1'b1;
              irq_set   = 1'b1;
              step_d    = '0;
            end
          end
          3'd5: begin
            quarter_d = 1'b1;
            half_d    = 1'b1;
            step_d    = '0;
          end
          default: step_d = '0;
        endcase
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      step_q    <= '0;
      mode_q    <= 1'b0;
      quarter_q <= 1'b0;
      half_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      mode_q    <= mode_d;
      quarter_q <= quarter_d;
      half_q    <= half_d;
    end
  end

  assign quarter_frame = quarter_q;
  assign half_frame    = half_q;
  assign step          = step_q;
  assign mode          = mode_q;

`ifdef APU_FRAME_IRQ_EN
  logic inhibit_q, inhibit_d;
  logic irq_q, irq_d;
  logic unused_wr_data;

  always_comb begin
    inhibit_d = inhibit_q;
    irq_d     = irq_q;
    if (status_rd) begin
      irq_d = 1'b0;
    end
    if (wr_4017) begin
      inhibit_d = wr_data[6];
      if (wr_data[6]) begin
        irq_d = 1'b0;
      end
    end else if (irq_set && !inhibit_q) begin
      // A set on the same clk as a status read wins.
      irq_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inhibit_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      inhibit_q <= inhibit_d;
      irq_q     <= irq_d;
    end
  end

  assign frame_irq      = irq_q;
  assign unused_wr_data = ^wr_data[5:0];
`else
  logic unused_irq_inputs;

  assign frame_irq         = 1'b0;
  assign unused_irq_inputs = ^{wr_data[6:0], status_rd, irq_set};
`endif

endmodule

// File: tb/tb_apu_frame_sequencer.sv
module tb_apu_frame_sequencer;

  localparam int unsigned StepCycles = 4;
`ifdef APU_FRAME_IRQ_EN
  localparam bit IrqEn = 1'b1;
`else
  localparam bit IrqEn = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       cpu_ce;
  logic       wr_4017;
  logic [7:0] wr_data;
  logic       status_rd;
  logic       quarter_frame;
  logic       half_frame;
  logic       frame_irq;
  logic [2:0] step;
  logic       mode;

  int tests;
  int fails;

  apu_frame_sequencer #(
    .STEP_CYCLES(StepCycles)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_ce       (cpu_ce),
    .wr_4017      (wr_4017),
    .wr_data      (wr_data),
    .status_rd    (status_rd),
    .quarter_frame(quarter_frame),
    .half_frame   (half_frame),
    .frame_irq    (frame_irq),
    .step         (step),
    .mode         (mode)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clk and settle just past the edge.
  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    cpu_ce    = 1'b0;
    wr_4017   = 1'b0;
    wr_data   = 8'h00;
    status_rd = 1'b0;
    clk1();
    reset = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] data);
    cpu_ce  = 1'b0;
    wr_4017 = 1'b1;
    wr_data = data;
    clk1();
    wr_4017 = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({quarter_frame, half_frame, frame_irq, step, mode} !== 7'b0) begin
      fails++;
      $display("FAIL reset_state: got %b expected %b",
               {quarter_frame, half_frame, frame_irq, step, mode}, 7'b0);
    end
  endtask

  // {q, h, irq, step} checked each tick.
  task automatic test_four_step();
    logic [5:0] exp;
    do_reset();
    cpu_ce = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      clk1();
      exp = {(t % 4 == 0), (t % 8 == 0), (IrqEn && t >= 16), 3'((t / 4) % 4)};
      tests++;
      if ({quarter_frame, half_frame, frame_irq, step} !== exp) begin
        fails++;
        $display("FAIL four_step tick %0d: got %b expected %b", t,
                 {quarter_frame, half_frame, frame_irq, step}, exp);
      end
    end
    tests++;
    if (mode !== 1'b0) begin
      fails++;
      $display("FAIL four_step_mode: got %b expected 0", mode);
    end
  endtask

  task automatic test_five_step();
    logic [5:0] exp;
    int b;
    int r;
    do_reset();
    do_write(8'h80);
    tests++;
    if ({quarter_frame, half_frame, frame_irq, step, mode} !== 7'b1100001) begin
      fails++;
      $display("FAIL five_step_write_pulse: got %b expected %b",
               {quarter_frame, half_frame, frame_irq, step, mode}, 7'b1100001);
    end
    cpu_ce = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      clk1();
      b = t / 4;
      r = (b > 0) ? (((b - 1) % 5) + 1) : 0;
      exp = {(t % 4 == 0 && r != 4), (t % 4 == 0 && (r == 2 || r == 5)), 1'b0,
             3'(b % 5)};
      tests++;
      if ({quarter_frame, half_frame, frame_irq, step} !== exp) begin
        fails++;
        $display("FAIL five_step tick %0d: got %b expected %b", t,
                 {quarter_frame, half_frame, frame_irq, step}, exp);
      end
    end
  endtask

  task automatic test_inhibit();
    do_reset();
    cpu_ce = 1'b1;
    repeat (16) clk1();
    tests++;
    if (frame_irq !== IrqEn) begin
      fails++;
      $display("FAIL inhibit_pre_irq: got %b expected %b", frame_irq, IrqEn);
    end
    do_write(8'h40);
    tests++;
    if ({quarter_frame, half_frame, frame_irq, step, mode} !== 7'b0) begin
      fails++;
      $display("FAIL inhibit_write_clear: got %b expected %b",
               {quarter_frame, half_frame, frame_irq, step, mode}, 7'b0);
    end
    cpu_ce = 1'b1;
    repeat (16) clk1();
    tests++;
    if ({quarter_frame, half_frame, frame_irq, step} !== 6'b110000) begin
      fails++;
      $display("FAIL inhibit_step4_no_irq: got %b expected %b",
               {quarter_frame, half_frame, frame_irq, step}, 6'b110000);
    end
    do_write(8'h00);
    cpu_ce = 1'b1;
    repeat (16) clk1();
    tests++;
    if (frame_irq !== IrqEn) begin
      fails++;
      $display("FAIL inhibit_reenabled_irq: got %b expected %b", frame_irq, IrqEn);
    end
  endtask

  task automatic test_status_read();
    do_reset();
    cpu_ce = 1'b1;
    repeat (15) clk1();
    tests++;
    if (frame_irq !== 1'b0) begin
      fails++;
      $display("FAIL status_pre_boundary: got %b expected 0", frame_irq);
    end
    status_rd = 1'b1;
    clk1();
    status_rd = 1'b0;
    tests++;
    if (frame_irq !== IrqEn) begin
      fails++;
      $display("FAIL status_same_clk_set_wins: got %b expected %b", frame_irq, IrqEn);
    end
    status_rd = 1'b1;
    clk1();
    status_rd = 1'b0;
    tests++;
    if (frame_irq !== 1'b0) begin
      fails++;
      $display("FAIL status_read_clear: got %b expected 0", frame_irq);
    end
  endtask

  task automatic test_write_on_boundary();
    do_reset();
    cpu_ce = 1'b1;
    repeat (7) clk1();
    wr_4017 = 1'b1;
    wr_data = 8'h00;
    clk1();
    wr_4017 = 1'b0;
    tests++;
    if ({quarter_frame, half_frame, step} !== 5'b0) begin
      fails++;
      $display("FAIL write_cancels_boundary: got %b expected %b",
               {quarter_frame, half_frame, step}, 5'b0);
    end
    for (int t = 1; t <= 4; t++) begin
      clk1();
      tests++;
      if ({quarter_frame, half_frame, step} !== ((t == 4) ? 5'b10001 : 5'b00000)) begin
        fails++;
        $display("FAIL write_restart tick %0d: got %b expected %b", t,
                 {quarter_frame, half_frame, step}, (t == 4) ? 5'b10001 : 5'b00000);
      end
    end
  endtask

  task automatic test_reset_mid_step();
    do_reset();
    do_write(8'h80);
    cpu_ce = 1'b1;
    repeat (15) clk1();
    // Reset lands on the edge where the tick-16 boundary would fire.
    reset = 1'b1;
    clk1();
    reset = 1'b0;
    tests++;
    if ({quarter_frame, half_frame, frame_irq, step, mode} !== 7'b0) begin
      fails++;
      $display("FAIL reset_mid_outputs: got %b expected %b",
               {quarter_frame, half_frame, frame_irq, step, mode}, 7'b0);
    end
    for (int t = 1; t <= 4; t++) begin
      clk1();
      tests++;
      if ({quarter_frame, half_frame, step} !== ((t == 4) ? 5'b10001 : 5'b00000)) begin
        fails++;
        $display("FAIL reset_mid_restart tick %0d: got %b expected %b", t,
                 {quarter_frame, half_frame, step}, (t == 4) ? 5'b10001 : 5'b00000);
      end
    end
  endtask

  task automatic test_gapped_ce();
    logic exp_q;
    do_reset();
    for (int c = 0; c < 36; c++) begin
      cpu_ce = (c % 3 == 0);
      clk1();
      exp_q = (c % 3 == 0) && (((c / 3) + 1) % 4 == 0);
      tests++;
      if (quarter_frame !== exp_q) begin
        fails++;
        $display("FAIL gapped_ce clk %0d: got %b expected %b", c, quarter_frame, exp_q);
      end
    end
    cpu_ce = 1'b0;
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    reset     = 1'b1;
    cpu_ce    = 1'b0;
    wr_4017   = 1'b0;
    wr_data   = 8'h00;
    status_rd = 1'b0;
    test_reset();
    test_four_step();
    test_five_step();
    test_inhibit();
    test_status_read();
    test_write_on_boundary();
    test_reset_mid_step();
    test_gapped_ce();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
